muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Iterative multiply/divide unit with its own HI/LO registers, the multicycle successor to the single-cycle control decode. Sits beside the ID stage: decodes Opcode/Funct of the instruction in ID, launches Mult/Multu/Div/Divu, holds the pipeline via Stall while a dependent or conflicting instruction waits, and supplies Mfhi/Mflo data. Width and throughput (bits retired per cycle) are parametrised.

## Interface
- WIDTH, 32: operand and HI/LO width.
- UNROLL, 1: bits processed per RUN cycle. Must divide WIDTH. N = WIDTH/UNROLL RUN cycles.
- Clock  in  1  rising-edge clock. Single clock domain; reset is asynchronous and active-low.
- Reset_n  in  1  asynchronous, active-low reset.
- Valid  in  1  instruction in ID is real (not bubble/flushed).
- Opcode  in  6  instruction opcode; only Op_R is acted on.
- Funct  in  6  Funct_Mult, Funct_Multu, Funct_Div, Funct_Divu, Funct_Mfhi, Funct_Mflo decoded; others ignored.
- Rs_Data  in  WIDTH  dividend / multiplicand.
- Rt_Data  in  WIDTH  divisor / multiplier.
- Stall  out  1  combinational; hold IF/ID, bubble EX.
- Busy  out  1  registered; operation in progress.
- Mf_Data  out  WIDTH  combinational; HI for Mfhi, LO for Mflo, else 0.
- DivByZero  out  1  registered one-cycle pulse.

## Operation
- is_md = Valid & Opcode==Op_R & Funct in {Mult,Multu,Div,Divu}; is_mf = Valid & Opcode==Op_R & Funct in {Mfhi,Mflo}.
- Stall = Busy & (is_md | is_mf). Start = is_md & !Busy.
- States: IDLE, RUN, FIX. IDLE -Start-> RUN (latch |Rs|,|Rt| for signed ops, raw for unsigned; record signs, op, zero-divisor; count=0). RUN: shift-add multiply or restoring divide, UNROLL bits/cycle; count increments; after count reaches N-1 -> FIX. FIX: apply signs, write HI/LO -> IDLE.
- Busy = state != IDLE.
- Multiply: {HI,LO} = 2*WIDTH-bit product; signed negates full product if signs differ.
- Divide: LO = quotient, HI = remainder; quotient sign = sign(Rs)^sign(Rt), remainder sign = sign(Rs).
- Signed overflow (most-negative / -1): LO = most-negative, HI = 0 (natural truncation).
- Divide by zero (signed or unsigned): full latency still taken; FIX writes HI = Rs as latched (original, not magnitude), LO = all ones; DivByZero pulses.
- Mf_Data reads HI/LO registers; valid whenever Stall is low.
- Reset_n low (any state, including mid-RUN): state=IDLE, count=0, HI=LO=0, DivByZero=0, Busy=0 immediately; in-flight op discarded.

## Timing
- Start accepted at edge ending cycle t. RUN cycles t+1..t+N, FIX t+N+1, HI/LO written at edge ending t+N+1.
- Busy high t+1..t+N+1; DivByZero high only in cycle t+N+2.
- Mfhi/Mflo or new is_md in t+1..t+N+1: Stall=1; same instruction in t+N+2: unstalled, new HI/LO visible / new op starts.
- Start cycle itself: Stall=0 (Busy low).
- Instructions other than is_md/is_mf never stall.
- Valid=0 suppresses start and Stall regardless of Opcode/Funct.

## Test plan
- WIDTH=32, UNROLL=1: Mult Rs=7, Rt=0xFFFFFFFD at t -> Busy t+1..t+33; Mfhi held from t+1 stalls through t+33; at t+34 Mf_Data=0xFFFFFFFF, then Mflo gives 0xFFFFFFEB.
- Multu 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; Mult 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
- Div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; Divu 0x80000000/3 -> LO=0x2AAAAAAA, HI=2; Div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Div Rs=0x12345678, Rt=0 -> HI=0x12345678, LO=0xFFFFFFFF, DivByZero=1 only in t+34; Divu same result.
- Mult with Valid=0 -> no start, Busy stays 0; Div at t then Divu at t+1 -> Stall t+1..t+33, Divu starts at t+34, Busy t+35..t+67.
- Reset_n low at t+10 mid-RUN -> Busy=0, HI=LO=0 before next edge, Stall=0; UNROLL=4 instance: Mult 3 x 5 -> Busy t+1..t+9, LO=15 at t+10.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit with private HI/LO registers, sitting beside ID.
// Launches Mult/Multu/Div/Divu, stalls dependent instructions, serves Mfhi/Mflo.
module muldiv_sequencer #(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Valid,
    input  logic [5:0]       Opcode,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] Rs_Data,
    input  logic [WIDTH-1:0] Rt_Data,
    output logic             Stall,
    output logic             Busy,
    output logic [WIDTH-1:0] Mf_Data,
    output logic             DivByZero,
    output logic [1:0]       Dbg_State
);

    localparam int N  = WIDTH / UNROLL;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [5:0] OP_R        = 6'h00;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] acc_q, acc_d, wk_q, wk_d, b_q, b_d, rs_q, rs_d;
    logic             div_q, div_d, sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
    logic             dbz_q, dbz_d;

    logic             is_op_r, is_md, is_mf, start, signed_op;
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] step_h, step_l, quo, rem;
    logic [2*WIDTH-1:0] prod;

    assign is_op_r = Valid && (Opcode == OP_R);
    assign is_md   = is_op_r && (Funct == FUNCT_MULT || Funct == FUNCT_MULTU ||
                                 Funct == FUNCT_DIV  || Funct == FUNCT_DIVU);
    assign is_mf   = is_op_r && (Funct == FUNCT_MFHI || Funct == FUNCT_MFLO);

    // Stall holds IF/ID while busy; an is_md seen with Stall low is taken that edge.
    assign Busy      = (state_q != S_IDLE);
    assign Stall     = Busy && (is_md || is_mf);
    assign start     = is_md && !Busy;
    assign signed_op = (Funct == FUNCT_MULT) || (Funct == FUNCT_DIV);
    assign DivByZero = dbz_q;
    assign Dbg_State = state_q;

    always_comb begin
        Mf_Data = '0;
        if (is_op_r && Funct == FUNCT_MFHI) Mf_Data = hi_q;
        else if (is_op_r && Funct == FUNCT_MFLO) Mf_Data = lo_q;
    end

    // UNROLL iterations of shift-add multiply or restoring divide on {acc, wk}.
    always_comb begin
        t      = '0;
        step_h = acc_q;
        step_l = wk_q;
        for (int i = 0; i < UNROLL; i++) begin
            if (!div_q) begin
                t      = step_l[0] ? ({1'b0, step_h} + {1'b0, b_q}) : {1'b0, step_h};
                step_h = t[WIDTH:1];
                step_l = {t[0], step_l[WIDTH-1:1]};
            end else begin
                t      = {step_h, step_l[WIDTH-1]};
                step_l = {step_l[WIDTH-2:0], 1'b0};
                if (t >= {1'b0, b_q}) begin
                    t         = t - {1'b0, b_q};
                    step_l[0] = 1'b1;
                end
                step_h = t[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        prod = {acc_q, wk_q};
        if (sa_q ^ sb_q) prod = -{acc_q, wk_q};
        quo = (sa_q ^ sb_q) ? -wk_q : wk_q;
        rem = sa_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        acc_d   = acc_q;
        wk_d    = wk_q;
        b_d     = b_q;
        rs_d    = rs_q;
        div_d   = div_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dz_d    = dz_q;
        dbz_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    count_d = '0;
                    div_d   = (Funct == FUNCT_DIV) || (Funct == FUNCT_DIVU);
                    sa_d    = signed_op && Rs_Data[WIDTH-1];
                    sb_d    = signed_op && Rt_Data[WIDTH-1];
                    wk_d    = (signed_op && Rs_Data[WIDTH-1]) ? -Rs_Data : Rs_Data;
                    b_d     = (signed_op && Rt_Data[WIDTH-1]) ? -Rt_Data : Rt_Data;
                    acc_d   = '0;
                    rs_d    = Rs_Data;
                    dz_d    = ((Funct == FUNCT_DIV) || (Funct == FUNCT_DIVU)) && (Rt_Data == '0);
                end
            end
            S_RUN: begin
                acc_d = step_h;
                wk_d  = step_l;
                if (count_q == CW'(N - 1)) state_d = S_FIX;
                else count_d = count_q + CW'(1);
            end
            S_FIX: begin
                state_d = S_IDLE;
                count_d = '0;
                if (!div_q) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (dz_q) begin
                    hi_d  = rs_q;
                    lo_d  = '1;
                    dbz_d = 1'b1;
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            acc_q   <= '0;
            wk_q    <= '0;
            b_q     <= '0;
            rs_q    <= '0;
            div_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dz_q    <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            acc_q   <= acc_d;
            wk_q    <= wk_d;
            b_q     <= b_d;
            rs_q    <= rs_d;
            div_q   <= div_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dz_q    <= dz_d;
            dbz_q   <= dbz_d;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: WIDTH=32 with UNROLL=1 and UNROLL=4 instances on shared inputs,
// results compared against plain 64-bit arithmetic.
module tb_muldiv_sequencer;

    localparam logic [5:0] F_MFHI = 6'h10, F_MFLO = 6'h12, F_MULT = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B, F_ADD = 6'h20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [5:0]  opcode = 6'h00;
    logic [5:0]  funct = 6'h00;
    logic [31:0] rs = 32'h0, rt = 32'h0;

    logic        stall1, busy1, dbz1, stall4, busy4, dbz4;
    logic [31:0] mf1, mf4;
    logic [1:0]  st1, st4;

    logic        sel = 1'b0;
    logic        o_stall, o_busy, o_dbz;
    logic [31:0] o_mf;

    int total = 0;
    int bad   = 0;

    muldiv_sequencer #(.WIDTH(32), .UNROLL(1)) dut1 (
        .Clock(clk), .Reset_n(rst_n), .Valid(valid), .Opcode(opcode), .Funct(funct),
        .Rs_Data(rs), .Rt_Data(rt), .Stall(stall1), .Busy(busy1), .Mf_Data(mf1),
        .DivByZero(dbz1), .Dbg_State(st1));

    muldiv_sequencer #(.WIDTH(32), .UNROLL(4)) dut4 (
        .Clock(clk), .Reset_n(rst_n), .Valid(valid), .Opcode(opcode), .Funct(funct),
        .Rs_Data(rs), .Rt_Data(rt), .Stall(stall4), .Busy(busy4), .Mf_Data(mf4),
        .DivByZero(dbz4), .Dbg_State(st4));

    always #5 clk = ~clk;

    always_comb begin
        o_stall = sel ? stall4 : stall1;
        o_busy  = sel ? busy4  : busy1;
        o_dbz   = sel ? dbz4   : dbz1;
        o_mf    = sel ? mf4    : mf1;
    end

    function automatic void ref_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        logic signed [63:0] sa, sb, sp, sq, sr;
        logic [63:0] up;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        dz = 1'b0;
        hi = 32'h0;
        lo = 32'h0;
        case (f)
            F_MULT:  begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
            F_MULTU: begin up = {32'h0, a} * {32'h0, b}; hi = up[63:32]; lo = up[31:0]; end
            F_DIV, F_DIVU: begin
                if (b == 32'h0) begin
                    dz = 1'b1; hi = a; lo = 32'hFFFF_FFFF;
                end else if (f == F_DIV) begin
                    sq = sa / sb; sr = sa % sb; lo = sq[31:0]; hi = sr[31:0];
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input logic edz);
        int n;
        n = sel ? 8 : 32;
        valid = 1'b1; opcode = 6'h00; funct = f; rs = a; rt = b;
        #1;
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL %s start_stall got=%b want=0", name, o_stall); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL %s start_busy got=%b want=0", name, o_busy); end
        @(posedge clk); #1;
        funct = F_MFHI;
        for (int k = 1; k <= n + 1; k++) begin
            #1;
            total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL %s busy c%0d got=%b want=1", name, k, o_busy); end
            total++; if (o_stall !== 1'b1) begin bad++; $display("FAIL %s stall c%0d got=%b want=1", name, k, o_stall); end
            total++; if (o_dbz !== 1'b0) begin bad++; $display("FAIL %s dbz c%0d got=%b want=0", name, k, o_dbz); end
            @(posedge clk); #1;
        end
        #1;
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL %s done_busy got=%b want=0", name, o_busy); end
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL %s done_stall got=%b want=0", name, o_stall); end
        total++; if (o_mf !== eh) begin bad++; $display("FAIL %s hi got=%h want=%h", name, o_mf, eh); end
        total++; if (o_dbz !== edz) begin bad++; $display("FAIL %s dbz_pulse got=%b want=%b", name, o_dbz, edz); end
        funct = F_MFLO;
        #1;
        total++; if (o_mf !== el) begin bad++; $display("FAIL %s lo got=%h want=%h", name, o_mf, el); end
        @(posedge clk); #1;
        valid = 1'b0;
        #1;
        total++; if (o_dbz !== 1'b0) begin bad++; $display("FAIL %s dbz_after got=%b want=0", name, o_dbz); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b1; opcode = 6'h00; funct = F_MFHI;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy1); end
        total++; if (stall1 !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall1); end
        total++; if (mf1 !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=0", mf1); end
        total++; if (dbz1 !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b want=0", dbz1); end
        total++; if (st1 !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", st1); end
        funct = F_MFLO; #1;
        total++; if (mf1 !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=0", mf1); end
        valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        sel = 1'b0;
        run_op("mult_7_m3",  F_MULT,  32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("multu_max",  F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_minsq", F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
        run_op("div_m7_2",   F_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu_min_3", F_DIVU,  32'h8000_0000, 32'd3,         32'd2,         32'h2AAA_AAAA, 1'b0);
        run_op("div_ovf",    F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0);
        run_op("div_zero",   F_DIV,   32'h1234_5678, 32'h0,         32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
        run_op("divu_zero",  F_DIVU,  32'h1234_5678, 32'h0,         32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
        run_op("div_zero_neg", F_DIV, 32'hFFFF_FF00, 32'h0,         32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1);
    endtask

    task automatic test_no_start();
        sel = 1'b0;
        valid = 1'b0; opcode = 6'h00; funct = F_MULT; rs = 32'd5; rt = 32'd6;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL novalid_busy c%0d got=%b want=0", k, busy1); end
            total++; if (stall1 !== 1'b0) begin bad++; $display("FAIL novalid_stall c%0d got=%b want=0", k, stall1); end
        end
        valid = 1'b1; opcode = 6'h1C;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL nonR_busy c%0d got=%b want=0", k, busy1); end
        end
        opcode = 6'h00; funct = F_ADD; #1;
        total++; if (mf1 !== 32'h0) begin bad++; $display("FAIL nonmf_data got=%h want=0", mf1); end
        @(posedge clk); #1;
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL add_busy got=%b want=0", busy1); end
        valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        valid = 1'b1; opcode = 6'h00; funct = F_DIV; rs = 32'hFFFF_FFF9; rt = 32'd2;
        #1;
        total++; if (stall1 !== 1'b0) begin bad++; $display("FAIL b2b_start_stall got=%b want=0", stall1); end
        @(posedge clk); #1;
        funct = F_DIVU; rs = 32'h8000_0000; rt = 32'd3;
        for (int k = 1; k <= 33; k++) begin
            #1;
            total++; if (stall1 !== 1'b1) begin bad++; $display("FAIL b2b_stall c%0d got=%b want=1", k, stall1); end
            @(posedge clk); #1;
        end
        #1;
        total++; if (stall1 !== 1'b0) begin bad++; $display("FAIL b2b_unstall got=%b want=0", stall1); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL b2b_gap_busy got=%b want=0", busy1); end
        @(posedge clk); #1;
        funct = F_ADD; #1;
        total++; if (stall1 !== 1'b0) begin bad++; $display("FAIL b2b_add_stall got=%b want=0", stall1); end
        for (int k = 35; k <= 67; k++) begin
            total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL b2b_busy2 c%0d got=%b want=1", k, busy1); end
            @(posedge clk); #2;
        end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL b2b_done_busy got=%b want=0", busy1); end
        funct = F_MFHI; #1;
        total++; if (mf1 !== 32'd2) begin bad++; $display("FAIL b2b_hi got=%h want=2", mf1); end
        funct = F_MFLO; #1;
        total++; if (mf1 !== 32'h2AAA_AAAA) begin bad++; $display("FAIL b2b_lo got=%h want=2aaaaaaa", mf1); end
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic test_random(input int count, input logic use4);
        logic [5:0]  f;
        logic [31:0] a, b, eh, el;
        logic        dz;
        sel = use4;
        for (int i = 0; i < count; i++) begin
            case ($urandom_range(0, 3))
                0: f = F_MULT;
                1: f = F_MULTU;
                2: f = F_DIV;
                default: f = F_DIVU;
            endcase
            a = $urandom();
            b = $urandom();
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 255));
                default: ;
            endcase
            ref_model(f, a, b, eh, el, dz);
            run_op($sformatf("rand%0d_u%0d_f%h", i, use4 ? 4 : 1, f), f, a, b, eh, el, dz);
        end
    endtask

    task automatic test_reset_mid_run();
        sel = 1'b0;
        valid = 1'b1; opcode = 6'h00; funct = F_MULT; rs = 32'd1234; rt = 32'd5678;
        @(posedge clk); #1;
        funct = F_MFHI;
        repeat (9) @(posedge clk);
        #1;
        total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL midrst_prebusy got=%b want=1", busy1); end
        rst_n = 1'b0; #1;
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy1); end
        total++; if (stall1 !== 1'b0) begin bad++; $display("FAIL midrst_stall got=%b want=0", stall1); end
        total++; if (mf1 !== 32'h0) begin bad++; $display("FAIL midrst_hi got=%h want=0", mf1); end
        funct = F_MFLO; #1;
        total++; if (mf1 !== 32'h0) begin bad++; $display("FAIL midrst_lo got=%h want=0", mf1); end
        total++; if (dbz1 !== 1'b0) begin bad++; $display("FAIL midrst_dbz got=%b want=0", dbz1); end
        valid = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL midrst_after c%0d got=%b want=0", k, busy1); end
        end
        valid = 1'b1; funct = F_MFLO; #1;
        total++; if (mf1 !== 32'h0) begin bad++; $display("FAIL midrst_lo_kept got=%h want=0", mf1); end
        valid = 1'b0;
    endtask

    task automatic test_unroll4();
        sel = 1'b1;
        run_op("u4_mult_3x5", F_MULT, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0);
        run_op("u4_div_zero", F_DIVU, 32'hCAFE_0001, 32'h0, 32'hCAFE_0001, 32'hFFFF_FFFF, 1'b1);
        test_random(6, 1'b1);
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_no_start();
        test_back_to_back();
        test_random(14, 1'b0);
        test_reset_mid_run();
        test_unroll4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
